// File: rtl/sar_logic.sv
// sar_logic: synchronous successive-approximation controller for an ADC_BITS
// SAR ADC, driving a capacitor DAC with monotonic switching.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high
//   start        conversion request, accepted only in IDLE
//   comp_out     comparator decision (1 = DAC output above threshold)
//   comp_valid   comp_out is valid this cycle (used only while waiting)
//   sample       track switch closed
//   comp_en      one-cycle comparator fire pulse
//   dac_data_h   per-cap high select, caps 1 (MSB) .. ADC_BITS-1
//   dac_data_l   per-cap low select; {h,l}: 10 vrefp, 01 vrefn, 00 vcm
//   dout         last completed conversion word
//   dout_valid   one-cycle strobe when dout is updated
//   busy         high in every state except IDLE
//   timeout_err  sticky forced-decision flag, cleared on accepted start
module sar_logic #(
    parameter int ADC_BITS      = 8,
    parameter int SAMPLE_CYCLES = 4,
    parameter int COMP_TIMEOUT  = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  comp_out,
    input  logic                  comp_valid,
    output logic                  sample,
    output logic                  comp_en,
    output logic [1:ADC_BITS-1]   dac_data_h,
    output logic [1:ADC_BITS-1]   dac_data_l,
    output logic [ADC_BITS-1:0]   dout,
    output logic                  dout_valid,
    output logic                  busy,
    output logic                  timeout_err
);

    localparam int KW  = $clog2(ADC_BITS + 1);
    localparam int CW  = $clog2(ADC_BITS);
    localparam int SCW = $clog2(SAMPLE_CYCLES + 1);
    localparam int WCW = $clog2(COMP_TIMEOUT + 1);
    localparam logic [KW-1:0] K_LAST = KW'(ADC_BITS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SAMPLE,
        S_COMP,
        S_WAIT,
        S_DONE
    } state_t;

    state_t              state;
    logic [KW-1:0]       bit_k;
    logic [SCW-1:0]      sample_cnt;
    logic [WCW-1:0]      wait_cnt;
    logic [ADC_BITS-1:0] shreg;

    logic                decide;
    logic                forced;
    logic                decision;
    logic [CW-1:0]       sr_idx;
    logic [CW-1:0]       cap_idx;
    logic [ADC_BITS-1:0] sr_next;

    // Decision resolution in WAIT; a timeout forces d = 0.
    always_comb begin
        decide   = (state == S_WAIT) &&
                   (comp_valid || (wait_cnt == WCW'(COMP_TIMEOUT - 1)));
        forced   = decide && !comp_valid;
        decision = comp_valid & comp_out;
        sr_idx   = CW'(K_LAST - bit_k);
        cap_idx  = CW'(bit_k);
        sr_next  = shreg;
        sr_next[sr_idx] = decision;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            bit_k       <= '0;
            sample_cnt  <= '0;
            wait_cnt    <= '0;
            shreg       <= '0;
            sample      <= 1'b0;
            comp_en     <= 1'b0;
            dac_data_h  <= '0;
            dac_data_l  <= '0;
            dout        <= '0;
            dout_valid  <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            comp_en    <= 1'b0;
            dout_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state       <= S_SAMPLE;
                        sample      <= 1'b1;
                        busy        <= 1'b1;
                        sample_cnt  <= SCW'(SAMPLE_CYCLES - 1);
                        bit_k       <= KW'(1);
                        shreg       <= '0;
                        dac_data_h  <= '0;
                        dac_data_l  <= '0;
                        timeout_err <= 1'b0;
                    end
                end
                S_SAMPLE: begin
                    if (sample_cnt == '0) begin
                        sample  <= 1'b0;
                        comp_en <= 1'b1;
                        state   <= S_COMP;
                    end else begin
                        sample_cnt <= sample_cnt - 1'b1;
                    end
                end
                S_COMP: begin
                    wait_cnt <= '0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (decide) begin
                        shreg <= sr_next;
                        if (forced) begin
                            timeout_err <= 1'b1;
                        end
                        if (bit_k != K_LAST) begin
                            // Only the cap for this bit moves; earlier caps stay put.
                            dac_data_h[cap_idx] <= ~decision;
                            dac_data_l[cap_idx] <= decision;
                            bit_k   <= bit_k + 1'b1;
                            comp_en <= 1'b1;
                            state   <= S_COMP;
                        end else begin
                            // Final bit goes straight into dout alongside the strobe.
                            dout       <= sr_next;
                            dout_valid <= 1'b1;
                            state      <= S_DONE;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sar_logic.sv
// tb_sar_logic: self-checking bench for sar_logic with a timeline model of
// one conversion (comparator fire cycles, decision edges, cap states).
module tb_sar_logic;

    localparam int N = 8;
    localparam int S = 4;
    localparam int T = 15;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         comp_out = 1'b0;
    logic         comp_valid = 1'b0;
    logic         sample, comp_en, dout_valid, busy, timeout_err;
    logic [1:N-1] dac_data_h, dac_data_l;
    logic [N-1:0] dout;

    sar_logic #(.ADC_BITS(N), .SAMPLE_CYCLES(S), .COMP_TIMEOUT(T)) dut (
        .clk(clk), .reset(reset), .start(start), .comp_out(comp_out),
        .comp_valid(comp_valid), .sample(sample), .comp_en(comp_en),
        .dac_data_h(dac_data_h), .dac_data_l(dac_data_l), .dout(dout),
        .dout_valid(dout_valid), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    int           lat [N];
    int           withhold;      // 0 = none, else bit number 1..N never answered
    logic [N-1:0] word;
    int           start_mode;    // 0 none, 1 fixed stray pulses, 2 random noise
    bit           chain;
    int           abort_cycle;
    logic [N-1:0] last_dout;

    logic [N-1:0] obs_dout;
    logic [1:N-1] obs_h, obs_l;
    logic         obs_terr;
    int           obs_dv, dv_count;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_conv();
        int           ce [N];
        int           de [N];
        logic         dd [N];
        int           c, dv;
        logic [N-1:0] exp_word;
        logic [1:N-1] eh, el;
        logic         ece, eterr;
        logic [N-1:0] edout;
        logic [26:0]  expv, actv;

        c = S + 1;
        exp_word = '0;
        for (int i = 0; i < N; i++) begin
            dd[i] = (withhold == i + 1) ? 1'b0 : word[N-1-i];
            ce[i] = c;
            de[i] = c + ((withhold == i + 1) ? T : lat[i]);
            c = de[i] + 1;
            exp_word[N-1-i] = dd[i];
        end
        dv = c;
        obs_dv = -1;
        dv_count = 0;

        if (!chain) @(negedge clk);
        start = 1'b1;
        comp_valid = 1'b0;

        for (int cyc = 1; cyc <= dv + 1; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            comp_valid = 1'b0;
            comp_out = 1'b0;

            ece = 1'b0;
            for (int i = 0; i < N; i++) if (ce[i] == cyc) ece = 1'b1;
            for (int i = 1; i < N; i++) begin
                if (cyc > de[i-1]) begin
                    eh[i] = ~dd[i-1];
                    el[i] = dd[i-1];
                end else begin
                    eh[i] = 1'b0;
                    el[i] = 1'b0;
                end
            end
            eterr = (withhold != 0) && (cyc > de[withhold-1]);
            edout = (cyc >= dv) ? exp_word : last_dout;
            expv = {cyc <= S, ece, cyc <= dv, cyc == dv, eterr, eh, el, edout};
            actv = {sample, comp_en, busy, dout_valid, timeout_err, dac_data_h, dac_data_l, dout};
            check($sformatf("cycle%0d", cyc), 64'(actv), 64'(expv));

            if (dout_valid) begin
                dv_count++;
                if (obs_dv < 0) begin
                    obs_dv = cyc;
                    obs_dout = dout;
                    obs_h = dac_data_h;
                    obs_l = dac_data_l;
                    obs_terr = timeout_err;
                end
            end

            if (abort_cycle == cyc) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                actv = {sample, comp_en, busy, dout_valid, timeout_err, dac_data_h, dac_data_l, dout};
                check("reset_abort", 64'(actv), 64'd0);
                last_dout = '0;
                return;
            end

            for (int i = 0; i < N; i++) begin
                if (de[i] == cyc && withhold != i + 1) begin
                    comp_valid = 1'b1;
                    comp_out = dd[i];
                end
            end
            if (start_mode == 2 && !comp_valid && (cyc <= S || ece) && $urandom_range(0, 1) == 1) begin
                comp_valid = 1'b1;
                comp_out = 1'($urandom_range(0, 1));
            end
            if (cyc <= dv) begin
                if (start_mode == 1)
                    start = (cyc == 3 || cyc == 10 || cyc == dv);
                else if (start_mode == 2)
                    start = ($urandom_range(0, 2) == 0);
            end
        end
        last_dout = exp_word;
    endtask

    typedef struct {
        logic [N-1:0] w;
        int           l;
        int           wh;
        logic [N-1:0] edout;
        logic [1:N-1] eh;
        logic [1:N-1] el;
        logic         eterr;
        int           elat;
    } vec_t;

    vec_t         tbl [5];
    logic [N-1:0] rexp;

    initial begin
        tbl[0] = '{8'hA5, 1, 0, 8'hA5, 7'b0101101, 7'b1010010, 1'b0, 21};
        tbl[1] = '{8'hFF, 1, 0, 8'hFF, 7'b0000000, 7'b1111111, 1'b0, 21};
        tbl[2] = '{8'h00, 1, 0, 8'h00, 7'b1111111, 7'b0000000, 1'b0, 21};
        tbl[3] = '{8'h3C, 3, 0, 8'h3C, 7'b1100001, 7'b0011110, 1'b0, 37};
        tbl[4] = '{8'hFF, 1, 3, 8'hDF, 7'b0010000, 7'b1101111, 1'b1, 35};

        last_dout = '0;
        chain = 1'b0;
        abort_cycle = 0;
        start_mode = 0;
        withhold = 0;

        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_state",
              64'({sample, comp_en, busy, dout_valid, timeout_err, dac_data_h, dac_data_l, dout}), 64'd0);
        reset = 1'b0;

        for (int t = 0; t < 5; t++) begin
            word = tbl[t].w;
            withhold = tbl[t].wh;
            for (int i = 0; i < N; i++) lat[i] = tbl[t].l;
            run_conv();
            check($sformatf("tbl%0d_dout", t), 64'(obs_dout), 64'(tbl[t].edout));
            check($sformatf("tbl%0d_dac_h", t), 64'(obs_h), 64'(tbl[t].eh));
            check($sformatf("tbl%0d_dac_l", t), 64'(obs_l), 64'(tbl[t].el));
            check($sformatf("tbl%0d_terr", t), 64'(obs_terr), 64'(tbl[t].eterr));
            check($sformatf("tbl%0d_latency", t), 64'(obs_dv), 64'(tbl[t].elat));
        end

        // Reset while waiting on bit 4, then a clean conversion.
        word = 8'hA5;
        withhold = 0;
        for (int i = 0; i < N; i++) lat[i] = 1;
        abort_cycle = 12;
        run_conv();
        check("abort_no_strobe", 64'(dv_count), 64'd0);
        abort_cycle = 0;
        run_conv();
        check("after_abort_dout", 64'(obs_dout), 64'hA5);

        // Stray starts at cycles 3, 10 and in DONE, then a start right after DONE.
        word = 8'h5A;
        start_mode = 1;
        run_conv();
        check("stray_start_strobes", 64'(dv_count), 64'd1);
        check("stray_start_dout", 64'(obs_dout), 64'h5A);
        start_mode = 0;
        chain = 1'b1;
        word = 8'hC3;
        run_conv();
        check("chained_dout", 64'(obs_dout), 64'hC3);
        check("chained_latency", 64'(obs_dv), 64'd21);
        chain = 1'b0;

        // Randomized conversions with comparator/start noise.
        start_mode = 2;
        for (int r = 0; r < 20; r++) begin
            word = N'($urandom);
            withhold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, N)) : 0;
            for (int i = 0; i < N; i++) lat[i] = int'($urandom_range(1, 4));
            rexp = word;
            if (withhold != 0) rexp[N-withhold] = 1'b0;
            run_conv();
            check($sformatf("rand%0d_dout", r), 64'(obs_dout), 64'(rexp));
            check($sformatf("rand%0d_terr", r), 64'(obs_terr), 64'(withhold != 0));
            check($sformatf("rand%0d_strobes", r), 64'(dv_count), 64'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
